// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// The lock FSM states are used only when FIFO_ARB_PKT_LOCK_EN is defined.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority encoder: selects the first set request at or after i_ptr,
// wrapping past NREQ-1 back to 0. Purely combinational.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [IW-1:0]   o_sel,
    output logic            o_any
);

    always_comb begin
        int          j;
        logic [IW-1:0] idx;
        o_sel = '0;
        o_any = 1'b0;
        j     = 0;
        idx   = '0;
        // Walk offsets from farthest to nearest so the nearest hit is the last write.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            idx = IW'(j);
            if (i_req[idx]) begin
                o_sel = idx;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers.
// Define FIFO_ARB_PKT_LOCK_EN to hold the grant on one producer until req_last.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int CNTW  = 16,
    localparam int IW    = idx_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*WIDTH-1:0] i_req_data,
    input  logic [NREQ-1:0]       i_req_last,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic                  i_fifo_full,
    output logic                  o_fifo_wen,
    output logic [WIDTH-1:0]      o_fifo_data,
    output logic                  o_grant_valid,
    output logic [IW-1:0]         o_grant_id,
    output logic [CNTW-1:0]       o_wr_count
);

    logic [IW-1:0]   r_ptr;
    logic [CNTW-1:0] r_wr_count;
    logic [NREQ-1:0] w_req;
    logic [IW-1:0]   w_sel;
    logic            w_any;
    logic            w_accept;

`ifdef FIFO_ARB_PKT_LOCK_EN
    arb_state_t    r_state;
    logic [IW-1:0] r_owner;

    // While locked, only the owner is visible to the picker.
    always_comb begin
        w_req = i_req_valid;
        if (r_state == ARB_LOCKED)
            w_req = i_req_valid & (NREQ'(1) << r_owner);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
        end else if (w_accept) begin
            case (r_state)
                ARB_IDLE: begin
                    if (!i_req_last[w_sel]) begin
                        r_state <= ARB_LOCKED;
                        r_owner <= w_sel;
                    end
                end
                ARB_LOCKED: begin
                    if (i_req_last[w_sel]) r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^i_req_last;
    assign w_req         = i_req_valid;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_sel (w_sel),
        .o_any (w_any)
    );

    // The picked requester is always valid, so a grant with room is an accepted beat.
    assign w_accept      = w_any & ~i_fifo_full & ~rst;
    assign o_fifo_wen    = w_accept;
    assign o_grant_valid = w_any;
    assign o_grant_id    = w_sel;
    assign o_fifo_data   = w_any ? i_req_data[int'(w_sel)*WIDTH +: WIDTH] : '0;
    assign o_wr_count    = r_wr_count;

    always_comb begin
        o_req_ready = '0;
        if (w_accept) o_req_ready[w_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_wr_count <= '0;
        end else if (w_accept) begin
            r_ptr      <= (w_sel == IW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
            r_wr_count <= r_wr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: a queue-free behavioural model of round-robin (and packet lock)
// checked every cycle on a 4-requester and a 3-requester instance, plus literal sequences.
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  va, la, rA;
    logic [31:0] da;
    logic        fa, wA, gvA;
    logic [7:0]  dA;
    logic [1:0]  gidA;
    logic [15:0] cA;

    logic [2:0]  vb, lb, rB;
    logic [23:0] db;
    logic        fb, wB, gvB;
    logic [7:0]  dB;
    logic [1:0]  gidB;
    logic [15:0] cB;

    fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .CNTW(16)) uA (
        .clk(clk), .rst(rst), .i_req_valid(va), .i_req_data(da), .i_req_last(la),
        .o_req_ready(rA), .i_fifo_full(fa), .o_fifo_wen(wA), .o_fifo_data(dA),
        .o_grant_valid(gvA), .o_grant_id(gidA), .o_wr_count(cA));

    fifo_wr_arbiter #(.NREQ(3), .WIDTH(8), .CNTW(16)) uB (
        .clk(clk), .rst(rst), .i_req_valid(vb), .i_req_data(db), .i_req_last(lb),
        .o_req_ready(rB), .i_fifo_full(fb), .o_fifo_wen(wB), .o_fifo_data(dB),
        .o_grant_valid(gvB), .o_grant_id(gidB), .o_wr_count(cB));

    int n_chk  = 0;
    int n_fail = 0;
    int m_ptr[2], m_cnt[2], m_own[2];
    bit m_lk[2];
    int accA[$];
    int accB[$];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: first valid requester scanning circularly from the model pointer.
    task automatic model_check(input int id, input int n, input logic [7:0] v, input logic [7:0] l,
                               input logic [63:0] d, input logic full, input logic gv,
                               input logic [7:0] gid, input logic [7:0] rdy, input logic wen,
                               input logic [7:0] data, input logic [15:0] cnt);
        bit          any;
        int          sel;
        logic [63:0] e_rdy;
        string       p;
        p = (id == 0) ? "A" : "B";
        if (rst) begin
            cmp({p, "_rst_ready"}, 64'(rdy), 64'd0);
            cmp({p, "_rst_wen"}, 64'(wen), 64'd0);
            m_ptr[id] = 0; m_cnt[id] = 0; m_lk[id] = 1'b0; m_own[id] = 0;
            return;
        end
        any = 1'b0; sel = 0;
        for (int k = 0; k < n; k++) begin
            int i;
            i = (m_ptr[id] + k) % n;
            if (!any && v[i] && (!m_lk[id] || i == m_own[id])) begin
                any = 1'b1;
                sel = i;
            end
        end
        e_rdy = '0;
        if (any && !full) e_rdy[sel] = 1'b1;
        cmp({p, "_grant_valid"}, 64'(gv), 64'(any));
        cmp({p, "_grant_id"}, 64'(gid), any ? 64'(sel) : 64'd0);
        cmp({p, "_ready"}, 64'(rdy), e_rdy);
        cmp({p, "_wen"}, 64'(wen), 64'(any && !full));
        cmp({p, "_data"}, 64'(data), any ? 64'(d[sel*8 +: 8]) : 64'd0);
        cmp({p, "_count"}, 64'(cnt), 64'(m_cnt[id]));
        if (wen) begin
            if (id == 0) accA.push_back(int'(gid));
            else         accB.push_back(int'(gid));
        end
        if (any && !full) begin
            m_ptr[id] = (sel + 1) % n;
            m_cnt[id] = (m_cnt[id] + 1) % 65536;
`ifdef FIFO_ARB_PKT_LOCK_EN
            if (!m_lk[id] && !l[sel]) begin
                m_lk[id]  = 1'b1;
                m_own[id] = sel;
            end else if (m_lk[id] && l[sel]) begin
                m_lk[id] = 1'b0;
            end
`else
            if (l[0] === 1'bx) m_lk[id] = 1'b0;
`endif
        end
    endtask

    always @(negedge clk) begin
        model_check(0, 4, {4'b0, va}, {4'b0, la}, {32'b0, da}, fa, gvA, {6'b0, gidA},
                    {4'b0, rA}, wA, dA, cA);
        model_check(1, 3, {5'b0, vb}, {5'b0, lb}, {40'b0, db}, fb, gvB, {6'b0, gidB},
                    {5'b0, rB}, wB, dB, cB);
    end

    function automatic logic [31:0] pack(input int id);
        logic [31:0] r;
        r = '0;
        if (id == 0) foreach (accA[i]) r = (r << 4) | 32'(accA[i]);
        else         foreach (accB[i]) r = (r << 4) | 32'(accB[i]);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int beats;
        va = 4'hF; la = 4'hF; da = 32'h44332211; fa = 1'b0;
        vb = 3'b0; lb = 3'h7; db = 24'h0;        fb = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        // Full rotation with all requesters valid.
        accA.delete();
        repeat (8) begin
            da = $urandom;
            step();
        end
        va = 4'h0;
        cmp("t2_count", 64'(cA), 64'd8);
        cmp("t2_len", 64'(accA.size()), 64'd8);
        cmp("t2_seq", 64'(pack(0)), 64'h01230123);

        // FIFO full freezes the pointer on the pending selection.
        accA.delete();
        va = 4'hF;
        step();
        fa = 1'b1;
        repeat (3) begin
            @(negedge clk);
            cmp("t3_full_gid", 64'(gidA), 64'd1);
            cmp("t3_full_wen", 64'(wA), 64'd0);
            step();
        end
        fa = 1'b0;
        step();
        va = 4'h0;
        cmp("t3_seq", 64'(pack(0)), 64'h01);
        cmp("t3_count", 64'(cA), 64'd10);

        // Three-beat packet from req1 against a continuously valid req0.
        va = 4'b0001; la = 4'hF;
        step();
        accA.delete();
        beats = 0;
        va = 4'b0011;
        repeat (5) begin
            la[1] = (beats == 2);
            va[1] = (beats < 3);
            @(negedge clk);
            if (rA[1] && va[1]) beats++;
            step();
        end
        va = 4'h0; la = 4'hF;
`ifdef FIFO_ARB_PKT_LOCK_EN
        cmp("t5_seq_lock", 64'(pack(0)), 64'h11100);
`else
        cmp("t5_seq_nolock", 64'(pack(0)), 64'h10101);
`endif

        // Reset in the middle of req2's packet.
        va = 4'b0100; la = 4'h0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        va = 4'b0110; la = 4'hF;
        @(negedge clk);
        cmp("t6_gid_after_rst", 64'(gidA), 64'd1);
        cmp("t6_wen_after_rst", 64'(wA), 64'd1);
        step();
        va = 4'h0;

        // Non-power-of-two wrap 2 -> 0.
        accB.delete();
        vb = 3'b100; db = 24'hCCBBAA;
        step();
        vb = 3'b011;
        repeat (2) step();
        vb = 3'b000;
        cmp("t4_len", 64'(accB.size()), 64'd3);
        cmp("t4_seq", 64'(pack(1)), 64'h201);

        // Randomized traffic on both instances with occasional resets.
        repeat (600) begin
            va  = 4'($urandom);  la = 4'($urandom);  da = $urandom;
            fa  = ($urandom_range(0, 3) == 0);
            vb  = 3'($urandom);  lb = 3'($urandom);  db = 24'($urandom);
            fb  = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0; va = 4'h0; vb = 3'h0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
